// File: rtl/arp_packet_receiver_pkg.sv
// Shared constants, field types and state encoding for the ARP frame receiver.
// Body offsets are byte positions counted from the first byte after the SFD.
package arp_packet_receiver_pkg;

  typedef logic [47:0] mac_address;
  typedef logic [31:0] ip_address;
  typedef logic [15:0] arp_operator;

  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [15:0] ARP_ETHERTYPE = 16'h0806;
  localparam logic [15:0] HTYPE         = 16'h0001;
  localparam logic [15:0] PTYPE         = 16'h0800;
  localparam logic [7:0]  HLEN          = 8'd6;
  localparam logic [7:0]  PLEN          = 8'd4;
  localparam logic [7:0]  PADDING       = 8'h00;

  localparam arp_operator ARP_OP_REQUEST = 16'd1;
  localparam arp_operator ARP_OP_REPLY   = 16'd2;
  localparam mac_address  BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  localparam int BODY_BYTES     = 60;
  localparam int PREAMBLE_BYTES = 7;

  localparam int DST_OFS   = 0;
  localparam int ETYPE_OFS = 12;
  localparam int HTYPE_OFS = 14;
  localparam int PTYPE_OFS = 16;
  localparam int HLEN_OFS  = 18;
  localparam int PLEN_OFS  = 19;
  localparam int OPER_OFS  = 20;
  localparam int SHA_OFS   = 22;
  localparam int SPA_OFS   = 28;
  localparam int THA_OFS   = 32;
  localparam int TPA_OFS   = 38;
  localparam int PAD_OFS   = 42;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_BODY,
    ST_CHECK
  } rx_state_e;

endpackage

// File: rtl/arp_packet_receiver_if.sv
// Byte stream in, parsed ARP fields and result pulses out.
// The master side feeds bytes and my_mac; the slave side is the receiver.
interface arp_packet_receiver_if;
  import arp_packet_receiver_pkg::*;

  logic [7:0]  rx_data;
  logic        rx_valid;
  mac_address  my_mac;
  logic        pkt_valid;
  logic        pkt_error;
  arp_operator oper;
  mac_address  sha;
  mac_address  tha;
  ip_address   spa;
  ip_address   tpa;

  modport master (
    output rx_data, rx_valid, my_mac,
    input  pkt_valid, pkt_error, oper, sha, tha, spa, tpa
  );

  modport slave (
    input  rx_data, rx_valid, my_mac,
    output pkt_valid, pkt_error, oper, sha, tha, spa, tpa
  );
endinterface

// File: rtl/arp_preamble_detector.sv
// Hunts for seven or more 0x55 bytes followed by the 0xD5 delimiter.
// sfd_found is high in the cycle the delimiter byte is presented, so the next byte is body byte 0.
module arp_preamble_detector
  import arp_packet_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hunt,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       sfd_found
);

  localparam logic [2:0] COUNT_MAX = 3'(PREAMBLE_BYTES);

  rx_state_e  state_q;
  logic [2:0] count_q;

  assign sfd_found = hunt && rx_valid && (state_q == ST_PREAMBLE) &&
                     (rx_data == SFD) && (count_q == COUNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else if (hunt && rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PREAMBLE) begin
            state_q <= ST_PREAMBLE;
            count_q <= 3'd1;
          end
        end
        ST_PREAMBLE: begin
          if (rx_data == PREAMBLE) begin
            if (count_q != COUNT_MAX) count_q <= count_q + 3'd1;
          end else begin
            // Valid SFD hands off to the body; anything else aborts the hunt.
            state_q <= ST_IDLE;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arp_packet_receiver.sv
// Ethernet/ARP frame receiver: stores the 60-byte body after the SFD, validates it in a
// single CHECK cycle and publishes the ARP fields of good frames.
module arp_packet_receiver
  import arp_packet_receiver_pkg::*;
#(
  parameter bit CHECK_PADDING = 1'b1,
  parameter bit FILTER_DST    = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  arp_packet_receiver_if.slave bus
);

  localparam logic [5:0] LAST_IDX = 6'(BODY_BYTES - 1);

  rx_state_e  state_q;
  logic [5:0] idx_q;
  logic [7:0] body_q [BODY_BYTES];
  logic       sfd_found;

  arp_preamble_detector u_preamble (
    .clk       (clk),
    .rst       (rst),
    .hunt      (state_q == ST_IDLE),
    .rx_valid  (bus.rx_valid),
    .rx_data   (bus.rx_data),
    .sfd_found (sfd_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sfd_found) begin
            state_q <= ST_BODY;
            idx_q   <= '0;
          end
        end
        ST_BODY: begin
          if (bus.rx_valid) begin
            if (idx_q == LAST_IDX) state_q <= ST_CHECK;
            else                   idx_q   <= idx_q + 6'd1;
          end
        end
        ST_CHECK: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the body buffer has no reset; every byte is rewritten before CHECK can read it.
  always_ff @(posedge clk) begin
    if (state_q == ST_BODY && bus.rx_valid) body_q[idx_q] <= bus.rx_data;
  end

  mac_address  rx_dst, rx_sha, rx_tha;
  ip_address   rx_spa, rx_tpa;
  arp_operator rx_oper;
  logic [15:0] rx_etype, rx_htype, rx_ptype;
  logic        pad_ok;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    rx_dst = '0;
    rx_sha = '0;
    rx_tha = '0;
    rx_spa = '0;
    rx_tpa = '0;
    pad_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_dst = {rx_dst[39:0], body_q[DST_OFS + i]};
      rx_sha = {rx_sha[39:0], body_q[SHA_OFS + i]};
      rx_tha = {rx_tha[39:0], body_q[THA_OFS + i]};
    end
    for (int i = 0; i < 4; i++) begin
      rx_spa = {rx_spa[23:0], body_q[SPA_OFS + i]};
      rx_tpa = {rx_tpa[23:0], body_q[TPA_OFS + i]};
    end
    for (int i = PAD_OFS; i < BODY_BYTES; i++) begin
      if (body_q[i] != PADDING) pad_ok = 1'b0;
    end
  end

  assign rx_etype = {body_q[ETYPE_OFS], body_q[ETYPE_OFS + 1]};
  assign rx_htype = {body_q[HTYPE_OFS], body_q[HTYPE_OFS + 1]};
  assign rx_ptype = {body_q[PTYPE_OFS], body_q[PTYPE_OFS + 1]};
  assign rx_oper  = {body_q[OPER_OFS],  body_q[OPER_OFS + 1]};

  logic hdr_ok, oper_ok, dst_ok, frame_good, in_check;

  assign hdr_ok     = (rx_etype == ARP_ETHERTYPE) && (rx_htype == HTYPE) && (rx_ptype == PTYPE) &&
                      (body_q[HLEN_OFS] == HLEN) && (body_q[PLEN_OFS] == PLEN);
  assign oper_ok    = (rx_oper == ARP_OP_REQUEST) || (rx_oper == ARP_OP_REPLY);
  assign dst_ok     = (rx_dst == bus.my_mac) || (rx_dst == BROADCAST_MAC);
  assign frame_good = hdr_ok && oper_ok && (!CHECK_PADDING || pad_ok) && (!FILTER_DST || dst_ok);
  assign in_check   = (state_q == ST_CHECK);

  // Verdict is decoded in the CHECK cycle itself so my_mac is sampled there and nowhere else.
  assign bus.pkt_valid = in_check && frame_good;
  assign bus.pkt_error = in_check && !frame_good;

  arp_operator oper_q;
  mac_address  sha_q, tha_q;
  ip_address   spa_q, tpa_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      oper_q <= '0;
      sha_q  <= '0;
      tha_q  <= '0;
      spa_q  <= '0;
      tpa_q  <= '0;
    end else if (bus.pkt_valid) begin
      oper_q <= rx_oper;
      sha_q  <= rx_sha;
      tha_q  <= rx_tha;
      spa_q  <= rx_spa;
      tpa_q  <= rx_tpa;
    end
  end

  // Fields show the new frame during the pkt_valid cycle, then the held copy.
  assign bus.oper = bus.pkt_valid ? rx_oper : oper_q;
  assign bus.sha  = bus.pkt_valid ? rx_sha  : sha_q;
  assign bus.tha  = bus.pkt_valid ? rx_tha  : tha_q;
  assign bus.spa  = bus.pkt_valid ? rx_spa  : spa_q;
  assign bus.tpa  = bus.pkt_valid ? rx_tpa  : tpa_q;

endmodule

// File: tb/tb_arp_packet_receiver.sv
// Directed bench for arp_packet_receiver: frames are assembled byte by byte from
// hand-chosen field values and the expected outputs are written out literally.
module tb_arp_packet_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arp_packet_receiver_if bus ();

  arp_packet_receiver #(
    .CHECK_PADDING (1'b1),
    .FILTER_DST    (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_55;
  localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_AA;
  localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

  int tests_run    = 0;
  int tests_failed = 0;
  int early_pulses = 0;
  logic [7:0] fr [68];

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] op,
                             input logic [47:0] s_ha, input logic [31:0] s_pa,
                             input logic [47:0] t_ha, input logic [31:0] t_pa, input logic [7:0] pad_last);
    for (int i = 0; i < 7; i++) fr[i] = 8'h55;
    fr[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      fr[8 + i]  = dst[47 - 8*i -: 8];
      fr[14 + i] = SRC_MAC[47 - 8*i -: 8];
      fr[30 + i] = s_ha[47 - 8*i -: 8];
      fr[40 + i] = t_ha[47 - 8*i -: 8];
    end
    fr[20] = etype[15:8]; fr[21] = etype[7:0];
    fr[22] = 8'h00;       fr[23] = 8'h01;
    fr[24] = 8'h08;       fr[25] = 8'h00;
    fr[26] = 8'h06;       fr[27] = 8'h04;
    fr[28] = op[15:8];    fr[29] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      fr[36 + i] = s_pa[31 - 8*i -: 8];
      fr[46 + i] = t_pa[31 - 8*i -: 8];
    end
    for (int i = 50; i < 68; i++) fr[i] = 8'h00;
    fr[67] = pad_last;
  endtask

  task automatic idle_cycle();
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    if (bus.pkt_valid || bus.pkt_error) early_pulses++;
  endtask

  // Sends fr[0..n-1]; returns #1 after the edge that consumed the last byte.
  task automatic send_frame(input int n, input int max_gap);
    early_pulses = 0;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0 && i > 0) begin
        int gap;
        gap = $urandom_range(0, max_gap);
        for (int g = 0; g < gap; g++) idle_cycle();
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = fr[i];
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      if (i != n - 1 && (bus.pkt_valid || bus.pkt_error)) early_pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.my_mac   = MY_MAC;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (bus.pkt_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pkt_valid: got %b want 0", bus.pkt_valid); end
    tests_run++; if (bus.pkt_error !== 1'b0) begin tests_failed++; $display("FAIL reset_pkt_error: got %b want 0", bus.pkt_error); end
    tests_run++; if (bus.oper !== 16'd0) begin tests_failed++; $display("FAIL reset_oper: got %h want 0", bus.oper); end
    tests_run++; if (bus.sha !== 48'd0 || bus.tha !== 48'd0) begin tests_failed++; $display("FAIL reset_ha: got sha=%h tha=%h want 0", bus.sha, bus.tha); end
    tests_run++; if (bus.spa !== 32'd0 || bus.tpa !== 32'd0) begin tests_failed++; $display("FAIL reset_pa: got spa=%h tpa=%h want 0", bus.spa, bus.tpa); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Checks a good request from 02:..:01 / 10.0.0.1 to 10.0.0.2, in the CHECK cycle and the one after.
  task automatic check_request(input string tag);
    tests_run++; if (early_pulses != 0) begin tests_failed++; $display("FAIL %s_early: got %0d pulses before last byte want 0", tag, early_pulses); end
    tests_run++; if (bus.pkt_valid !== 1'b1 || bus.pkt_error !== 1'b0) begin tests_failed++; $display("FAIL %s_pulse: got valid=%b error=%b want 1/0", tag, bus.pkt_valid, bus.pkt_error); end
    tests_run++; if (bus.oper !== 16'd1) begin tests_failed++; $display("FAIL %s_oper: got %h want 0001", tag, bus.oper); end
    tests_run++; if (bus.sha !== 48'h02_00_00_00_00_01 || bus.tha !== 48'd0) begin tests_failed++; $display("FAIL %s_ha: got sha=%h tha=%h want 020000000001/0", tag, bus.sha, bus.tha); end
    tests_run++; if (bus.spa !== 32'h0A00_0001 || bus.tpa !== 32'h0A00_0002) begin tests_failed++; $display("FAIL %s_pa: got spa=%h tpa=%h want 0a000001/0a000002", tag, bus.spa, bus.tpa); end
    @(posedge clk); #1;
    tests_run++; if (bus.pkt_valid !== 1'b0 || bus.pkt_error !== 1'b0) begin tests_failed++; $display("FAIL %s_one_cycle: got valid=%b error=%b want 0/0", tag, bus.pkt_valid, bus.pkt_error); end
    tests_run++; if (bus.sha !== 48'h02_00_00_00_00_01 || bus.tpa !== 32'h0A00_0002) begin tests_failed++; $display("FAIL %s_hold: got sha=%h tpa=%h want held", tag, bus.sha, bus.tpa); end
  endtask

  task automatic build_request();
    build_frame(BCAST, 16'h0806, 16'd1, 48'h02_00_00_00_00_01, 32'h0A00_0001, 48'd0, 32'h0A00_0002, 8'h00);
  endtask

  task automatic test_basic_request();
    build_request();
    send_frame(68, 0);
    check_request("basic");
  endtask

  task automatic test_gaps();
    build_request();
    send_frame(68, 5);
    check_request("gaps");
  endtask

  task automatic check_rejected(input string tag);
    tests_run++; if (early_pulses != 0) begin tests_failed++; $display("FAIL %s_early: got %0d pulses want 0", tag, early_pulses); end
    tests_run++; if (bus.pkt_error !== 1'b1 || bus.pkt_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_pulse: got valid=%b error=%b want 0/1", tag, bus.pkt_valid, bus.pkt_error); end
    tests_run++; if (bus.oper !== 16'd1 || bus.sha !== 48'h02_00_00_00_00_01 || bus.spa !== 32'h0A00_0001) begin tests_failed++; $display("FAIL %s_fields: got oper=%h sha=%h spa=%h want previous", tag, bus.oper, bus.sha, bus.spa); end
    @(posedge clk); #1;
    tests_run++; if (bus.pkt_error !== 1'b0) begin tests_failed++; $display("FAIL %s_one_cycle: got error=%b want 0", tag, bus.pkt_error); end
  endtask

  task automatic test_bad_ethertype();
    build_frame(BCAST, 16'h0800, 16'd2, 48'h02_00_00_00_00_07, 32'h0A00_0007, 48'd0, 32'h0A00_0008, 8'h00);
    send_frame(68, 0);
    check_rejected("ethertype");
  endtask

  task automatic test_bad_padding();
    build_frame(BCAST, 16'h0806, 16'd2, 48'h02_00_00_00_00_07, 32'h0A00_0007, 48'd0, 32'h0A00_0008, 8'h01);
    send_frame(68, 0);
    check_rejected("padding");
  endtask

  task automatic test_short_preamble();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = (i < 6) ? 8'h55 : 8'hD5;
      @(posedge clk); #1;
      if (bus.pkt_valid || bus.pkt_error) pulses++;
    end
    build_request();
    send_frame(68, 0);
    tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL short_preamble_pulse: got %0d pulses want 0", pulses); end
    check_request("after_short_preamble");
  endtask

  task automatic test_filter_dst();
    build_frame(48'h02_00_00_00_00_99, 16'h0806, 16'd2, 48'h02_00_00_00_00_07, 32'h0A00_0007, 48'd0, 32'h0A00_0008, 8'h00);
    send_frame(68, 0);
    check_rejected("foreign_dst");
    build_frame(MY_MAC, 16'h0806, 16'd2, 48'h02_00_00_00_00_02, 32'h0A00_0002, 48'h02_00_00_00_00_01, 32'h0A00_0001, 8'h00);
    send_frame(68, 0);
    tests_run++; if (bus.pkt_valid !== 1'b1 || bus.pkt_error !== 1'b0) begin tests_failed++; $display("FAIL my_dst_pulse: got valid=%b error=%b want 1/0", bus.pkt_valid, bus.pkt_error); end
    tests_run++; if (bus.oper !== 16'd2) begin tests_failed++; $display("FAIL my_dst_oper: got %h want 0002", bus.oper); end
    tests_run++; if (bus.sha !== 48'h02_00_00_00_00_02 || bus.tha !== 48'h02_00_00_00_00_01) begin tests_failed++; $display("FAIL my_dst_ha: got sha=%h tha=%h", bus.sha, bus.tha); end
    tests_run++; if (bus.spa !== 32'h0A00_0002 || bus.tpa !== 32'h0A00_0001) begin tests_failed++; $display("FAIL my_dst_pa: got spa=%h tpa=%h", bus.spa, bus.tpa); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    build_request();
    send_frame(8 + 30, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = fr[38];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    pulses = (bus.pkt_valid || bus.pkt_error) ? 1 : 0;
    tests_run++; if (bus.oper !== 16'd0 || bus.sha !== 48'd0 || bus.tpa !== 32'd0) begin tests_failed++; $display("FAIL abort_fields_cleared: got oper=%h sha=%h tpa=%h want 0", bus.oper, bus.sha, bus.tpa); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.pkt_valid || bus.pkt_error) pulses++;
    end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL abort_pulse: got %0d pulses want 0", pulses); end
    send_frame(68, 0);
    check_request("after_abort");
  endtask

  initial begin
    test_reset();
    test_basic_request();
    test_gaps();
    test_bad_ethertype();
    test_bad_padding();
    test_short_preamble();
    test_filter_dst();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arp_packet_receiver.md
ARP_PACKET_RECEIVER -- requirements
Module: arp_packet_receiver

Interface
REQ-001 Parameter: CHECK_PADDING, 1, when 1 a nonzero padding byte marks the frame bad.
REQ-002 Parameter: FILTER_DST, 1, when 1 only frames with dest MAC = my_mac or broadcast are accepted.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset is synchronous and active-high.
REQ-005 rx_data  input  8  received byte, wire order, MSB-first within each multi-byte field.
REQ-006 rx_valid  input  1  rx_data qualifier; a byte is consumed on each clk with rx_valid=1.
REQ-007 my_mac  input  mac_address  local MAC for destination filtering.
REQ-008 pkt_valid  output  1  one-cycle pulse: good ARP frame parsed.
REQ-009 pkt_error  output  1  one-cycle pulse: frame fully received but rejected.
REQ-010 oper  output  arp_operator  ARP operation of last good frame.
REQ-011 sha, tha  output  mac_address  sender/target hardware address of last good frame.
REQ-012 spa, tpa  output  ip_address  sender/target protocol address of last good frame.

Function
REQ-013 Frame = 7x PREAMBLE byte 0x55, SFD 0xD5, 60 body bytes: dst MAC(6), src MAC(6), ethertype(2), HTYPE(2), PTYPE(2), HLEN(1), PLEN(1), OPER(2), SHA(6), SPA(4), THA(6), TPA(4), padding(18); 68 bytes total, no FCS.
REQ-014 FSM states: IDLE, PREAMBLE, BODY, CHECK.
REQ-015 IDLE: on valid 0x55 -> PREAMBLE with preamble count=1; any other byte stays IDLE.
REQ-016 PREAMBLE: 0x55 increments count (saturate at 7); 0xD5 with count>=7 -> BODY, byte index=0; 0xD5 with count<7 or any other byte -> IDLE, no pulse.
REQ-017 BODY: each valid byte stored at its index; index 59 consumed -> CHECK.
REQ-018 rx_valid=0 in any state SHALL hold state, counters and stored bytes (gaps allowed, no timeout).
REQ-019 CHECK lasts exactly one cycle, ignores rx_data, then -> IDLE; pkt_valid or pkt_error asserts in the CHECK cycle (one cycle after last body byte accepted).
REQ-020 Frame good iff ethertype=ARP_ETHERTYPE, HTYPE=1, PTYPE=0x0800, HLEN=6, PLEN=4, OPER in {1,2}, padding all zero (if CHECK_PADDING), dst in {my_mac, ff:ff:ff:ff:ff:ff} (if FILTER_DST).
REQ-021 Good frame: oper/sha/spa/tha/tpa update in the same cycle pkt_valid asserts; held until next good frame.
REQ-022 Bad frame: pkt_error pulses, field outputs unchanged.
REQ-023 pkt_valid and pkt_error never asserted together; each high exactly one cycle per frame.
REQ-024 my_mac sampled in CHECK cycle only.

Reset
REQ-025 rst=1 -> state IDLE, all counters 0, pkt_valid=0, pkt_error=0, oper=0, sha=0, spa=0, tha=0, tpa=0.
REQ-026 Reset mid-frame discards partial frame with no pulse; rst dominates rx_valid in the same cycle.

Structure
REQ-027 Shared package gains: ARP_OP_REQUEST=1, ARP_OP_REPLY=2, BROADCAST_MAC, BODY_BYTES=60, PREAMBLE_BYTES=7, receiver state enum; existing PREAMBLE, SFD, ARP_ETHERTYPE, HTYPE, PTYPE, HLEN, PLEN, PADDING constants and mac_address/ip_address/arp_operator types reused.
REQ-028 One sub-module arp_preamble_detector (IDLE/PREAMBLE hunt, outputs one-cycle sfd_found); body capture and checks in top level.

Verification
REQ-029 Valid request, dst broadcast, sha 02:00:00:00:00:01, spa 10.0.0.1, tpa 10.0.0.2 -> pkt_valid one cycle after byte 68, oper=1, fields match.
REQ-030 Same frame with random rx_valid gaps (up to 5 idle cycles) -> identical outputs and timing relative to last byte.
REQ-031 Ethertype 0x0800 -> pkt_error pulse, fields keep previous values.
REQ-032 6x 0x55 then 0xD5 -> no pulse; following correct frame back-to-back -> pkt_valid.
REQ-033 FILTER_DST=1, dst 02:00:00:00:00:99 != my_mac -> pkt_error; dst=my_mac, oper=2 -> pkt_valid, oper=2.
REQ-034 rst asserted at body byte 30, then full good frame -> no pulse for aborted frame, pkt_valid for second.
